dbus_responder: RTL
===================

# dbus_responder

Data-bus responder serving the pipelined core's memory-stage port: it answers every data access with a word-addressed RAM plus a small memory-mapped I/O region (LED register, free-running cycle counter, 8N1 serial transmitter). It sits beside the core in the top-level and is driven directly by the core's `MemWrite`, `ALUResult` and `WriteData`, returning `ReadData` in the same cycle.

## Interface
- `RAM_WORDS`, 64: data RAM depth in 32-bit words, power of two, at most 64.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit, ≥2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low; `reset==0` at a rising edge resets all state except RAM contents.
- `MemWrite` in 1: write strobe for the current cycle.
- `ALUResult` in 32: byte address of the access.
- `WriteData` in 32: store data.
- `ReadData` out 32: load data, combinational from the current address.
- `leds` out 8: LED register.
- `tx` out 1: serial output, idles high.

## Operation
- Address map, decoded on `ALUResult`; bits [1:0] are ignored, so all accesses are whole-word:
  - 0x000–0x0FF: RAM, index `ALUResult[7:2]` modulo `RAM_WORDS`. Read/write.
  - 0x100 LEDS: read returns {24'b0, leds}. A write loads `WriteData[7:0]`.
  - 0x104 CYCLES: read returns the 32-bit counter. Writes are ignored.
  - 0x108 TXDATA: reads return 0. A write starts a transmission of `WriteData[7:0]` only when the transmitter is idle; a write while busy is dropped silently.
  - 0x10C TXSTAT: read returns {31'b0, busy}. Writes are ignored.
  - Any other address: reads return 0 and writes are ignored.
- Cycle counter: increments by 1 every cycle the block is not in reset. Wraps from 0xFFFF_FFFF to 0.
- Transmitter FSM states and transitions:
  - IDLE: `tx`=1. An accepted write moves it to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then DATA.
  - DATA: sends 8 bits LSB first, each held `CLKS_PER_BIT` cycles, then STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles, then IDLE.
- `busy` is 1 in every state except IDLE.
- The transmitted byte is latched at acceptance. Later writes never alter a frame in progress.

## Timing
- Reset values:
  - `leds`=0, counter=0, FSM=IDLE, `tx`=1, `busy`=0.
  - RAM is not cleared.
  - `ReadData` reflects these values combinationally.
- Reads have zero latency: `ReadData` is a pure function of `ALUResult` and current state.
- A read of an address written in the same cycle returns the old value. The new value is visible from the next cycle.
- Reading CYCLES in cycle N returns the pre-increment value; the same read in cycle N+1 returns that value +1.
- TXDATA write at edge E:
  - From E, the FSM is in START: `tx`=0 and TXSTAT reads 1.
  - Frame length is exactly 10·`CLKS_PER_BIT` cycles.
  - At edge E+10·`CLKS_PER_BIT` the FSM returns to IDLE and `busy`=0.
  - A write accepted in that same cycle starts a new frame immediately, with no gap.
- Reset asserted mid-frame: at that edge the FSM goes to IDLE, `tx`=1 and `busy`=0. The frame is abandoned with no stop bit.
- Reset with `MemWrite`=1: reset wins and the write is ignored. This applies to RAM as well as MMIO.

## Structure
- Shared package `dbus_pkg`:
  - Address constants (`RAM_LIMIT`, `ADDR_LEDS`, `ADDR_CYCLES`, `ADDR_TXDATA`, `ADDR_TXSTAT`).
  - Transmitter state encoding (IDLE/START/DATA/STOP).
- Sub-module `uart_tx` (params `CLKS_PER_BIT`):
  - Ports: `clk`, `reset`, `start`, `data[7:0]`, `tx`, `busy`.
  - Contains the FSM, bit counter (0–7) and baud counter (0..`CLKS_PER_BIT`−1).
- The top level holds the RAM array, the LED and counter registers, and the read mux.

## Test plan
- Reset, then read 0x100/0x104/0x10C → 0 / 0 / 0; `tx`=1; `leds`=0.
- Write 0xDEADBEEF to 0x040, then read 0x040 → 0xDEADBEEF. Read 0x043 → 0xDEADBEEF (low bits ignored). Read 0x200 → 0.
- Write 0x1A5 to 0x100 → `leds`=0xA5 next cycle. Write to 0x104 → counter unchanged, keeps incrementing. Preload to near-wrap via forced value 0xFFFF_FFFF → next read 0.
- With `CLKS_PER_BIT`=4, write 0x55 to 0x108 → `tx` sequence per 4 cycles: 0,1,0,1,0,1,0,1,0,1. TXSTAT=1 for exactly 40 cycles, then 0.
- Write 0x55, then write 0xFF to 0x108 mid-frame → frame bits still 0x55, no second frame. Write 0x0F on the cycle busy drops → back-to-back frame, start bit immediately.
- Assert `reset`=0 at bit 3 of a frame → `tx`=1 and TXSTAT=0 next cycle. RAM word written before reset still reads back its old value.

Source files
------------

// File: rtl/dbus_pkg.sv
// Shared address map and transmitter state encoding for the data-bus responder.
package dbus_pkg;

    localparam logic [31:0] RAM_LIMIT   = 32'h0000_0100;
    localparam logic [31:0] ADDR_LEDS   = 32'h0000_0100;
    localparam logic [31:0] ADDR_CYCLES = 32'h0000_0104;
    localparam logic [31:0] ADDR_TXDATA = 32'h0000_0108;
    localparam logic [31:0] ADDR_TXSTAT = 32'h0000_010C;

    typedef enum logic [1:0] {
        TxIdle,
        TxStart,
        TxData,
        TxStop
    } tx_state_e;

endpackage

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: start bit, eight data bits LSB first, one stop bit.
module uart_tx
    import dbus_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

    tx_state_e        state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       data_q, data_d;
    logic             baud_done;

    assign baud_done = (baud_q == BaudLast);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= TxIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        data_d  = data_q;
        tx      = 1'b1;
        busy    = 1'b1;
        unique case (state_q)
            TxIdle: begin
                busy = 1'b0;
                // The byte is captured here so later bus writes cannot disturb the frame.
                if (start) begin
                    state_d = TxStart;
                    data_d  = data;
                    baud_d  = '0;
                end
            end
            TxStart: begin
                tx = 1'b0;
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = TxData;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            TxData: begin
                tx = data_q[bit_q];
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = TxStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            TxStop: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = TxIdle;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            default: state_d = TxIdle;
        endcase
    end

endmodule

// File: rtl/dbus_responder.sv
// Memory-stage responder: word RAM plus LED, cycle-counter and serial-TX registers.
module dbus_responder
    import dbus_pkg::*;
#(
    parameter int unsigned RAM_WORDS    = 64,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  leds,
    output logic        tx
);

    localparam int unsigned IdxW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    logic [31:0]     ram_q [RAM_WORDS];
    logic [IdxW-1:0] ram_idx;
    logic [31:0]     word_addr;
    logic            is_ram;
    logic            tx_start;
    logic            tx_busy;
    logic [7:0]      leds_q, leds_d;
    logic [31:0]     cycles_q, cycles_d;

    assign word_addr = {ALUResult[31:2], 2'b00};
    assign is_ram    = (ALUResult < RAM_LIMIT);
    assign ram_idx   = ALUResult[IdxW+1:2];
    assign tx_start  = MemWrite && (word_addr == ADDR_TXDATA);

    // RAM contents survive reset, but a write coinciding with reset is discarded.
    always_ff @(posedge clk) begin
        if (reset && MemWrite && is_ram) begin
            ram_q[ram_idx] <= WriteData;
        end
    end

    always_comb begin
        leds_d   = leds_q;
        cycles_d = cycles_q + 32'd1;
        if (MemWrite && (word_addr == ADDR_LEDS)) begin
            leds_d = WriteData[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            leds_q   <= '0;
            cycles_q <= '0;
        end else begin
            leds_q   <= leds_d;
            cycles_q <= cycles_d;
        end
    end

    always_comb begin
        ReadData = '0;
        if (is_ram) begin
            ReadData = ram_q[ram_idx];
        end else begin
            case (word_addr)
                ADDR_LEDS:   ReadData = {24'b0, leds_q};
                ADDR_CYCLES: ReadData = cycles_q;
                ADDR_TXSTAT: ReadData = {31'b0, tx_busy};
                default:     ReadData = '0;
            endcase
        end
    end

    assign leds = leds_q;

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk  (clk),
        .reset(reset),
        .start(tx_start),
        .data (WriteData[7:0]),
        .tx   (tx),
        .busy (tx_busy)
    );

endmodule
